// File: rtl/seq_rca_pkg.sv
// rtl/seq_rca_pkg.sv - shared types and default constants for the sequential ripple-carry adder
//
// Purpose : FSM state enumeration and default geometry for seq_rca.
// Contents: state_e (ST_IDLE / ST_RUN / ST_DONE), DEF_WIDTH, DEF_CHUNK,
//           and a helper that sizes the chunk index counter.
package seq_rca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Width of a counter able to hold 0 .. n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational CHUNK-bit ripple-carry adder built from full-adder cells
//
// Purpose : one chunk of the sequential adder's datapath.
// Modules : full_adder - single-bit full-adder cell
//           rca_slice  - W cells chained LSB to MSB
// Ports (rca_slice):
//   a, b   in  [W-1:0]  chunk operands
//   cin    in  1        carry into bit 0
//   sum    out [W-1:0]  chunk sum
//   cout   out 1        carry out of bit W-1
//   c_msb  out 1        carry into bit W-1 (with cout gives signed overflow)

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  // c[i] is the carry into bit i; c[W] is the carry out of the slice.
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_cell
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/seq_rca.sv
// rtl/seq_rca.sv - sequential ripple-carry adder/subtractor, CHUNK bits per cycle
//
// Purpose : adds (or subtracts) two WIDTH-bit operands over N = WIDTH/CHUNK
//           cycles using a single reused rca_slice. WIDTH must be a multiple
//           of CHUNK.
// Optional: define SEQ_RCA_ACCUM_EN to add the acc input; acc=1 at the
//           handshake substitutes the last completed sum for operand A.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands presented
//   in_ready   out  1      accepting operands (IDLE only)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in for addition
//   sub        in   1      1 = A - B
//   acc        in   1      (SEQ_RCA_ACCUM_EN only) use last sum as A
//   out_valid  out  1      result available (DONE only)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      two's-complement overflow

module seq_rca
  import seq_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef SEQ_RCA_ACCUM_EN
  input  logic             acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_width(N);

  localparam logic [1:0]    IDLE     = ST_IDLE;
  localparam logic [1:0]    RUN      = ST_RUN;
  localparam logic [1:0]    DONE     = ST_DONE;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             sub_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic [WIDTH-1:0] a_sel;
  int unsigned      base;

  logic [CHUNK-1:0] sl_a;
  logic [CHUNK-1:0] sl_b;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_cout;
  logic             sl_cmsb;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready & in_valid;

`ifdef SEQ_RCA_ACCUM_EN
  // sum_q still holds the last completed result while IDLE (0 after reset),
  // so it doubles as the accumulator register.
  assign a_sel = acc ? sum_q : a;
`else
  assign a_sel = a;
`endif

  // Bit offset of the chunk being worked on this cycle.
  assign base = 32'(idx) * 32'(CHUNK);

  assign sl_a = a_q[base +: CHUNK];
  assign sl_b = b_q[base +: CHUNK];

  rca_slice #(
    .W (CHUNK)
  ) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry),
    .sum   (sl_sum),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction is A + ~B + 1: invert B now, force carry-in to 1.
            a_q   <= a_sel;
            b_q   <= sub ? ~b : b;
            sub_q <= sub;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          sum_q[base +: CHUNK] <= sl_sum;
          carry                <= sl_cout;
          if (idx == LAST_IDX) begin
            // The final chunk holds the MSB: its carries give cout and ovf.
            cout_q <= sl_cout;
            ovf_q  <= sl_cmsb ^ sl_cout;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/seq_rca.md
SEQ_RCA -- requirements
Module: seq_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle. WIDTH SHALL be a multiple of CHUNK. N = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: operands presented.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in, used when sub=0.
REQ-010 SHALL have port sub, input, 1: 1 = subtract (A - B).
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry out of bit WIDTH-1.
REQ-015 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 In IDLE with in_valid=1 (handshake), SHALL register a, b (inverted if sub=1), sub, and carry = (sub ? 1 : cin), clear the chunk index, and enter RUN.
REQ-018 In RUN, each cycle SHALL add chunk k of the registered operands plus the stored carry, write the chunk-k sum bits, and store the new carry.
REQ-019 SHALL leave RUN for DONE after chunk N-1; out_valid SHALL rise exactly N cycles after the handshake cycle.
REQ-020 SHALL set cout = carry out of bit WIDTH-1; for sub=1, cout=1 means no borrow.
REQ-021 SHALL set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-022 In DONE, SHALL hold sum, cout and ovf stable while out_ready=0; on out_ready=1, SHALL enter IDLE the next cycle.
REQ-023 SHALL sample inputs only on the handshake; input changes during RUN or DONE SHALL have no effect.
REQ-024 Minimum issue interval SHALL be N+2 cycles; there is no DONE-to-accept bypass.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-026 While rst=1, SHALL force state IDLE, out_valid=0, sum=0, cout=0, ovf=0, chunk index 0 and carry 0.
REQ-027 in_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-028 rst in RUN or DONE SHALL abort the operation without producing a result, and the aborted result SHALL never appear.

Configuration
REQ-029 With macro SEQ_RCA_ACCUM_EN defined, SHALL add input port acc (1 bit). acc=1 at the handshake SHALL replace operand A with the last completed sum (0 after reset).
REQ-030 Without SEQ_RCA_ACCUM_EN, port acc and the feedback path SHALL be absent, and behaviour SHALL be as in REQ-017 to REQ-025.

Structure
REQ-031 Package seq_rca_pkg SHALL hold the state enum (IDLE/RUN/DONE) and default parameter constants.
REQ-032 Sub-module rca_slice SHALL be a combinational CHUNK-bit ripple-carry adder built from full-adder cells. It SHALL output sum, carry out, and carry into its MSB; the last of these feeds ovf.
REQ-033 seq_rca SHALL instantiate exactly one rca_slice, reused every RUN cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-034 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid rises 4 cycles after the handshake.
REQ-035 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-036 sub=1, 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-037 out_ready held low 3 cycles in DONE -> sum, cout and out_valid stable, in_ready=0; a in_valid pulse meanwhile is ignored.
REQ-038 rst asserted in the 2nd RUN cycle -> next cycle IDLE, outputs 0, no out_valid; a following op 0x0001+0x0001 gives 0x0002.
REQ-039 With SEQ_RCA_ACCUM_EN: op 0x0010+0x0005, then acc=1 with b=0x0003 -> second sum=0x0018.
